// File: rtl/weight_stream_pkg.sv
// weight_stream_pkg: shared defaults and FSM encoding for the weight stream reader
package weight_stream_pkg;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_DEPTH  = 28;
    localparam int DEF_ADDR_W = 5;
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
endpackage

// File: rtl/weight_stream_reader_fifo.sv
// weight_fifo2: two-entry FIFO holding {idx, last, data} between the BRAM and the consumer
module weight_fifo2 #(
    parameter int W = 22
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic [1:0]   count
);
    logic [W-1:0] mem [2];
    logic         wp;
    logic         rp;
    assign dout = mem[rp];
    // storage and pointers; push and pop may happen in the same cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wp     <= 1'b0;
            rp     <= 1'b0;
            count  <= '0;
        end else begin
            if (push) mem[wp] <= din;
            wp    <= wp ^ push;
            rp    <= rp ^ pop;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end
endmodule

// File: rtl/weight_stream_reader.sv
// weight_stream_reader: streams DEPTH BRAM weights to the MAC over valid/ready with index and last flag
module weight_stream_reader import weight_stream_pkg::*; #(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    output logic              BUSY,
    output logic              DONE,
    output logic              BRAM_EN,
    output logic              BRAM_WE,
    output logic [ADDR_W-1:0] BRAM_ADDR,
    input  logic [DATA_W-1:0] BRAM_DO,
    output logic [DATA_W-1:0] W_DATA,
    output logic [ADDR_W-1:0] W_IDX,
    output logic              W_LAST,
    output logic              W_VALID,
    input  logic              W_READY
);
    localparam int CW = ADDR_W + 1;
    localparam int FW = ADDR_W + 1 + DATA_W;
    localparam logic [CW-1:0]     CNT_END  = CW'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    state_t            state, state_n;
    logic [CW-1:0]     issue_cnt, cnt_n;
    logic [ADDR_W-1:0] addr_n;
    logic              busy_n, done_n, issue, pop, inflight, room;
    logic [2:0]        occ;
    logic [FW-1:0]     head;
    logic [1:0]        count;

    // a read issued last cycle is on the BRAM output now and lands in the FIFO this edge
    assign inflight = BRAM_EN;
    assign BRAM_WE  = 1'b0;
    assign W_VALID  = count != 2'd0;
    assign pop      = W_VALID & W_READY;
    assign W_DATA   = head[DATA_W-1:0];
    assign W_LAST   = head[DATA_W] & W_VALID;
    assign W_IDX    = head[FW-1 -: ADDR_W];
    assign occ      = {1'b0, count} - {2'b0, pop} + {2'b0, inflight};
    assign room     = occ < 3'd2;

    weight_fifo2 #(.W(FW)) u_fifo (
        .clk   (CLK),
        .rst   (RST),
        .push  (inflight),
        .pop   (pop),
        .din   ({BRAM_ADDR, BRAM_ADDR == LAST_IDX, BRAM_DO}),
        .dout  (head),
        .count (count)
    );

    // next state and issue decision; a read only goes out when its FIFO slot is guaranteed
    always_comb begin
        state_n = state;
        busy_n  = BUSY;
        done_n  = 1'b0;
        issue   = 1'b0;
        addr_n  = BRAM_ADDR;
        cnt_n   = issue_cnt;
        case (state)
            IDLE: if (START) begin
                state_n = (DEPTH == 1) ? DRAIN : FETCH;
                busy_n  = 1'b1;
                issue   = 1'b1;
                addr_n  = '0;
                cnt_n   = CW'(1);
            end
            FETCH: if (room && issue_cnt < CNT_END) begin
                issue   = 1'b1;
                addr_n  = issue_cnt[ADDR_W-1:0];
                cnt_n   = issue_cnt + CW'(1);
                state_n = (issue_cnt == CNT_END - CW'(1)) ? DRAIN : FETCH;
            end
            DRAIN: if (pop && W_LAST) begin
                state_n = IDLE;
                busy_n  = 1'b0;
                done_n  = 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    // registered FSM state and BRAM control outputs
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            BRAM_EN   <= 1'b0;
            BRAM_ADDR <= '0;
            issue_cnt <= '0;
        end else begin
            state     <= state_n;
            BUSY      <= busy_n;
            DONE      <= done_n;
            BRAM_EN   <= issue;
            BRAM_ADDR <= addr_n;
            issue_cnt <= cnt_n;
        end
    end
endmodule

// File: tb/tb_weight_stream_reader.sv
// tb_weight_stream_reader: scoreboard bench for the weight stream reader
module tb_weight_stream_reader;
    logic        CLK = 1'b0, RST = 1'b1, START = 1'b0, W_READY = 1'b1;
    logic        BUSY, DONE, BRAM_EN, BRAM_WE, W_LAST, W_VALID;
    logic [4:0]  BRAM_ADDR, W_IDX;
    logic [15:0] BRAM_DO = '0, W_DATA;

    logic        START1 = 1'b0;
    logic        BUSY1, DONE1, EN1, WE1, LAST1, VALID1;
    logic [4:0]  ADDR1, IDX1;
    logic [15:0] DO1 = '0, DATA1;

    typedef struct packed { logic [4:0] idx; logic last; logic [15:0] data; } exp_t;
    exp_t exp_q[$];
    int   issue_log[$];
    int   n_cmp = 0, n_fail = 0, cyc = 0;
    int   issued = 0, accepted = 0, done_cnt = 0, first_acc = -1, last_acc = 0;
    bit   prev_stall = 0, prev_last_acc = 0;
    logic [15:0] prev_data;
    logic [4:0]  prev_idx;

    always #5 CLK = ~CLK;

    weight_stream_reader dut (
        .CLK(CLK), .RST(RST), .START(START), .BUSY(BUSY), .DONE(DONE),
        .BRAM_EN(BRAM_EN), .BRAM_WE(BRAM_WE), .BRAM_ADDR(BRAM_ADDR), .BRAM_DO(BRAM_DO),
        .W_DATA(W_DATA), .W_IDX(W_IDX), .W_LAST(W_LAST), .W_VALID(W_VALID), .W_READY(W_READY)
    );

    weight_stream_reader #(.DEPTH(1)) dut1 (
        .CLK(CLK), .RST(RST), .START(START1), .BUSY(BUSY1), .DONE(DONE1),
        .BRAM_EN(EN1), .BRAM_WE(WE1), .BRAM_ADDR(ADDR1), .BRAM_DO(DO1),
        .W_DATA(DATA1), .W_IDX(IDX1), .W_LAST(LAST1), .W_VALID(VALID1), .W_READY(1'b1)
    );

    always @(negedge CLK) if (BRAM_EN) BRAM_DO <= 16'h0100 + 16'(BRAM_ADDR);
    always @(negedge CLK) if (EN1) DO1 <= 16'hBEEF;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic load_exp();
        for (int i = 0; i < 28; i++) exp_q.push_back({5'(i), (i == 27), 16'(16'h0100 + i)});
        first_acc = -1;
    endtask

    task automatic wait_done(input int d0);
        int k = 0;
        while (done_cnt == d0 && k < 300) begin
            step();
            k++;
        end
        if (done_cnt == d0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL wait_done: timed out after %0d cycles", k);
        end
        step();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"}, BUSY, 0);
        chk({tag, "_done"}, DONE, 0);
        chk({tag, "_en"}, BRAM_EN, 0);
        chk({tag, "_addr"}, BRAM_ADDR, 0);
        chk({tag, "_valid"}, W_VALID, 0);
        chk({tag, "_data"}, W_DATA, 0);
        chk({tag, "_idx"}, W_IDX, 0);
        chk({tag, "_last"}, W_LAST, 0);
    endtask

    // monitor: pops the scoreboard on every handshake and checks the stream invariants
    always @(negedge CLK) begin
        exp_t e;
        if (!RST) begin
            chk("bram_we", BRAM_WE, 0);
            chk("addr_range", BRAM_ADDR <= 5'd27, 1);
            if (BRAM_EN) begin
                issued++;
                issue_log.push_back(BRAM_ADDR);
            end
            chk("outstanding_le2", (issued - accepted) <= 2, 1);
            if (prev_stall) begin
                chk("stall_valid", W_VALID, 1);
                chk("stall_data", W_DATA, prev_data);
                chk("stall_idx", W_IDX, prev_idx);
            end
            if (DONE) begin
                done_cnt++;
                chk("done_after_last", prev_last_acc, 1);
                chk("busy_at_done", BUSY, 0);
            end
            prev_last_acc = 0;
            if (W_VALID && W_READY) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL spurious_word: got idx %0d data 0x%0h with nothing expected", W_IDX, W_DATA);
                end else begin
                    e = exp_q.pop_front();
                    chk("w_data", W_DATA, e.data);
                    chk("w_idx", W_IDX, e.idx);
                    chk("w_last", W_LAST, e.last);
                end
                if (first_acc < 0) first_acc = cyc;
                last_acc = cyc;
                accepted++;
                prev_last_acc = W_LAST;
            end
            prev_stall = W_VALID && !W_READY;
            prev_data  = W_DATA;
            prev_idx   = W_IDX;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
        $fatal(1);
    end

    initial begin
        int a0, d0, i0, k;
        // reset values
        step();
        step();
        chk_reset_vals("rst");
        RST = 1'b0;
        step();

        // full stream with W_READY held high
        a0 = accepted;
        d0 = done_cnt;
        load_exp();
        START = 1'b1;
        step();
        START = 1'b0;
        chk("t1_busy", BUSY, 1);
        chk("t1_en0", BRAM_EN, 1);
        chk("t1_addr0", BRAM_ADDR, 0);
        chk("t1_valid_early", W_VALID, 0);
        step();
        chk("t1_valid_t1", W_VALID, 1);
        chk("t1_first_data", W_DATA, 16'h0100);
        wait_done(d0);
        chk("t1_words", accepted - a0, 28);
        chk("t1_dones", done_cnt - d0, 1);
        chk("t1_no_bubble", last_acc - first_acc, 27);
        chk("t1_busy_after", BUSY, 0);
        chk("t1_addr_hold", BRAM_ADDR, 27);
        chk("t1_q_empty", exp_q.size(), 0);

        // W_READY pattern 1,0,0,1
        a0 = accepted;
        d0 = done_cnt;
        load_exp();
        START = 1'b1;
        step();
        START = 1'b0;
        k = 0;
        while (done_cnt == d0 && k < 400) begin
            W_READY = (k % 4 == 0) || (k % 4 == 3);
            step();
            k++;
        end
        W_READY = 1'b1;
        step();
        chk("t2_words", accepted - a0, 28);
        chk("t2_dones", done_cnt - d0, 1);
        chk("t2_q_empty", exp_q.size(), 0);

        // consumer stalled for 10 cycles
        a0 = accepted;
        d0 = done_cnt;
        i0 = issue_log.size();
        load_exp();
        W_READY = 1'b0;
        START = 1'b1;
        step();
        START = 1'b0;
        repeat (10) step();
        chk("t3_issued", issue_log.size() - i0, 2);
        chk("t3_addr_a", issue_log[i0], 0);
        chk("t3_addr_b", issue_log[i0 + 1], 1);
        chk("t3_en_idle", BRAM_EN, 0);
        chk("t3_valid", W_VALID, 1);
        chk("t3_head_idx", W_IDX, 0);
        W_READY = 1'b1;
        wait_done(d0);
        chk("t3_words", accepted - a0, 28);
        chk("t3_total_issued", issue_log.size() - i0, 28);

        // START while busy and in the DONE edge
        a0 = accepted;
        d0 = done_cnt;
        load_exp();
        START = 1'b1;
        step();
        START = 1'b0;
        repeat (4) step();
        START = 1'b1;
        step();
        START = 1'b0;
        k = 0;
        while (!(W_VALID && W_READY && W_LAST) && k < 100) begin
            step();
            k++;
        end
        START = 1'b1;
        step();
        START = 1'b0;
        repeat (3) step();
        chk("t4_words", accepted - a0, 28);
        chk("t4_dones", done_cnt - d0, 1);
        chk("t4_busy", BUSY, 0);
        chk("t4_en", BRAM_EN, 0);
        chk("t4_valid", W_VALID, 0);

        // reset mid-stream after 10 words
        a0 = accepted;
        load_exp();
        START = 1'b1;
        step();
        START = 1'b0;
        k = 0;
        while (accepted - a0 < 10 && k < 100) begin
            step();
            k++;
        end
        #1 RST = 1'b1;
        #1 chk_reset_vals("t5");
        exp_q.delete();
        prev_stall = 0;
        issued = accepted;
        #1 RST = 1'b0;
        step();
        a0 = accepted;
        d0 = done_cnt;
        load_exp();
        START = 1'b1;
        step();
        START = 1'b0;
        wait_done(d0);
        chk("t5_words", accepted - a0, 28);
        chk("t5_q_empty", exp_q.size(), 0);

        // single-entry instance
        START1 = 1'b1;
        step();
        START1 = 1'b0;
        chk("d1_busy", BUSY1, 1);
        chk("d1_en", EN1, 1);
        step();
        chk("d1_valid", VALID1, 1);
        chk("d1_last", LAST1, 1);
        chk("d1_idx", IDX1, 0);
        chk("d1_data", DATA1, 16'hBEEF);
        chk("d1_en_off", EN1, 0);
        step();
        chk("d1_done", DONE1, 1);
        chk("d1_busy_off", BUSY1, 0);
        chk("d1_valid_off", VALID1, 0);
        chk("d1_we", WE1, 0);
        step();
        chk("d1_done_pulse", DONE1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
